// File: rtl/pool_max_stream.sv
// Streaming per-lane max-pooling stage.
// Folds WINDOW accepted vectors into one vector that holds each lane's maximum.
// The stage is always ready; out_valid pulses for one cycle per completed window.
module pool_max_stream #(
    parameter int SIZE   = 4,
    parameter int WINDOW = 4,
    localparam int CNT_W = $clog2(WINDOW)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [8*SIZE-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    output logic [8*SIZE-1:0] out_data,
    output logic [CNT_W-1:0]  win_pos
);

    localparam logic [CNT_W-1:0] LastPos = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] OnePos  = CNT_W'(1);

    logic [8*SIZE-1:0] runMax_q, runMax_d;
    logic [8*SIZE-1:0] outData_q, outData_d;
    logic              outValid_q, outValid_d;
    logic [CNT_W-1:0]  winPos_q, winPos_d;
    logic [8*SIZE-1:0] laneMax;

    // Unsigned per-lane maximum of the running max and the incoming vector.
    always_comb begin
        laneMax = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (in_data[8*i +: 8] > runMax_q[8*i +: 8]) begin
                laneMax[8*i +: 8] = in_data[8*i +: 8];
            end else begin
                laneMax[8*i +: 8] = runMax_q[8*i +: 8];
            end
        end
    end

    // Next state: clear beats completion; the first element of a window is loaded, not compared.
    always_comb begin
        runMax_d   = runMax_q;
        outData_d  = outData_q;
        outValid_d = 1'b0;
        winPos_d   = winPos_q;
        if (clear) begin
            if (in_valid) begin
                runMax_d = in_data;
                winPos_d = OnePos;
            end else begin
                winPos_d = '0;
            end
        end else if (in_valid) begin
            if (winPos_q == '0) begin
                runMax_d = in_data;
                winPos_d = OnePos;
            end else if (winPos_q == LastPos) begin
                outData_d  = laneMax;
                outValid_d = 1'b1;
                winPos_d   = '0;
            end else begin
                runMax_d = laneMax;
                winPos_d = winPos_q + OnePos;
            end
        end
    end

    // State registers, cleared immediately by the active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            runMax_q   <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            winPos_q   <= '0;
        end else begin
            runMax_q   <= runMax_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            winPos_q   <= winPos_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign win_pos   = winPos_q;

endmodule

// File: tb/tb_pool_max_stream.sv
// Directed testbench for pool_max_stream with a queue-based scoreboard.
// A behavioural model keeps the accepted elements of the open window and
// pushes the per-lane maximum of the whole window when it completes.
module tb_pool_max_stream;

   localparam int SIZE   = 4;
   localparam int WINDOW = 4;
   localparam int CNT_W  = $clog2(WINDOW);

   logic              clock;
   logic              reset;
   logic              inValid;
   logic [8*SIZE-1:0] inData;
   logic              clear;
   logic              outValid;
   logic [8*SIZE-1:0] outData;
   logic [CNT_W-1:0]  winPos;

   int checks = 0;
   int errors = 0;

   logic [8*SIZE-1:0] expQ[$];
   logic [8*SIZE-1:0] winItems[$];
   bit                expPulse;
   logic [8*SIZE-1:0] lastOut;
   int                modelPos;

   pool_max_stream #(.SIZE(SIZE), .WINDOW(WINDOW)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (inValid),
      .in_data  (inData),
      .clear    (clear),
      .out_valid(outValid),
      .out_data (outData),
      .win_pos  (winPos)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Per-lane maximum over every element collected in the window.
   function automatic logic [8*SIZE-1:0] windowMax(input logic [8*SIZE-1:0] items[$]);
      logic [8*SIZE-1:0] result;
      logic [7:0]        best;
      logic [7:0]        cand;
      result = '0;
      for (int lane = 0; lane < SIZE; lane++) begin
         best = items[0][8*lane +: 8];
         foreach (items[k]) begin
            cand = items[k][8*lane +: 8];
            if (cand > best) best = cand;
         end
         result[8*lane +: 8] = best;
      end
      return result;
   endfunction

   // Single counted comparison with an immediate assertion.
   task automatic compareVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
      end
   endtask

   // Compare all outputs against the model after an edge.
   task automatic checkOutput(input string tag);
      logic [8*SIZE-1:0] expData;
      compareVal({tag, " win_pos"}, 32'(winPos), 32'(modelPos));
      compareVal({tag, " out_valid"}, 32'(outValid), 32'(expPulse));
      if (outValid === 1'b1) begin
         if (expQ.size() == 0) begin
            compareVal({tag, " unexpected pulse"}, 32'(outValid), 32'd0);
         end else begin
            expData = expQ.pop_front();
            lastOut = expData;
         end
      end
      compareVal({tag, " out_data"}, outData, lastOut);
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then check.
   task automatic applyStimulus(input bit valid, input logic [8*SIZE-1:0] data, input bit clr, input string tag);
      @(negedge clock);
      inValid = valid;
      inData  = data;
      clear   = clr;
      @(posedge clock);
      expPulse = 1'b0;
      if (clr) begin
         winItems.delete();
         if (valid) winItems.push_back(data);
      end else if (valid) begin
         winItems.push_back(data);
         if (winItems.size() == WINDOW) begin
            expQ.push_back(windowMax(winItems));
            expPulse = 1'b1;
            winItems.delete();
         end
      end
      modelPos = winItems.size();
      #1;
      checkOutput(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(1'b0, 32'h0, 1'b0, tag);
   endtask

   initial begin
      reset    = 1'b0;
      inValid  = 1'b0;
      inData   = '0;
      clear    = 1'b0;
      expPulse = 1'b0;
      lastOut  = '0;
      modelPos = 0;

      $display("[TB] test 1: reset");
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         inValid = 1'b1;
         inData  = $urandom();
         @(posedge clock);
         #1;
         compareVal("reset out_valid", 32'(outValid), 32'd0);
         compareVal("reset out_data", outData, 32'd0);
         compareVal("reset win_pos", 32'(winPos), 32'd0);
      end
      @(negedge clock);
      inValid = 1'b0;
      reset   = 1'b1;
      applyStimulus(1'b1, 32'h11223344, 1'b0, "post-reset a0");
      applyStimulus(1'b1, 32'h01010101, 1'b0, "post-reset a1");
      applyStimulus(1'b1, 32'h55000000, 1'b0, "post-reset a2");
      applyStimulus(1'b1, 32'h00000066, 1'b0, "post-reset a3");
      idle("post-reset pulse");

      $display("[TB] test 2: basic window");
      applyStimulus(1'b1, 32'h01020304, 1'b0, "basic v0");
      applyStimulus(1'b1, 32'h1F1C355E, 1'b0, "basic v1");
      applyStimulus(1'b1, 32'h8080C8FF, 1'b0, "basic v2");
      applyStimulus(1'b1, 32'h100F1C31, 1'b0, "basic v3");
      compareVal("basic known result", outData, 32'h8080C8FF);
      idle("basic after");

      $display("[TB] test 4: fresh window reload");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h05050505, 1'b0, "reload");
      compareVal("reload known result", outData, 32'h05050505);

      $display("[TB] test 3: bubbles");
      begin
         logic [31:0] vecs[4];
         vecs[0] = 32'h01020304;
         vecs[1] = 32'h1F1C355E;
         vecs[2] = 32'h8080C8FF;
         vecs[3] = 32'h100F1C31;
         for (int v = 0; v < 4; v++) begin
            applyStimulus(1'b1, vecs[v], 1'b0, "bubble accept");
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) idle("bubble idle");
         end
      end
      idle("bubble tail");
      compareVal("bubble known result", outData, 32'h8080C8FF);

      $display("[TB] test 5: clear");
      applyStimulus(1'b1, 32'hC8C8C8C8, 1'b0, "clear v0");
      applyStimulus(1'b1, 32'h09090909, 1'b0, "clear v1");
      applyStimulus(1'b1, 32'h07070707, 1'b1, "clear with data");
      applyStimulus(1'b1, 32'h01010101, 1'b0, "clear v3");
      applyStimulus(1'b1, 32'h02020202, 1'b0, "clear v4");
      applyStimulus(1'b1, 32'h03030303, 1'b0, "clear v5");
      compareVal("clear known result", outData, 32'h07070707);
      applyStimulus(1'b0, 32'h0, 1'b1, "clear idle empty");
      applyStimulus(1'b1, 32'hAAAAAAAA, 1'b0, "clear-last v0");
      applyStimulus(1'b1, 32'hBBBBBBBB, 1'b0, "clear-last v1");
      applyStimulus(1'b1, 32'hCCCCCCCC, 1'b0, "clear-last v2");
      applyStimulus(1'b1, 32'h0D0D0D0D, 1'b1, "clear at last");
      idle("clear-last no pulse");
      applyStimulus(1'b0, 32'h0, 1'b1, "clear idle");
      applyStimulus(1'b1, 32'h0F0E0D0C, 1'b0, "after clear v0");
      applyStimulus(1'b1, 32'h01020304, 1'b0, "after clear v1");
      applyStimulus(1'b1, 32'h00000000, 1'b0, "after clear v2");
      applyStimulus(1'b1, 32'h10000010, 1'b0, "after clear v3");

      $display("[TB] test 6: reset mid-window");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hFAFAFAFA, 1'b0, "mid-reset fill");
      #2;
      reset = 1'b0;
      #1;
      compareVal("async reset out_valid", 32'(outValid), 32'd0);
      compareVal("async reset out_data", outData, 32'd0);
      compareVal("async reset win_pos", 32'(winPos), 32'd0);
      winItems.delete();
      modelPos = 0;
      lastOut  = '0;
      @(negedge clock);
      inValid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h0A141E28, 1'b0, "post mid-reset");
      compareVal("mid-reset known result", outData, 32'h0A141E28);
      idle("final idle");

      compareVal("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
